fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request/response handshake. Sits between the imem port and decode. It issues one fetch at a time and holds the returned word until decode consumes it. It arbitrates PC redirects (trap over branch) and discards any response made stale by a redirect.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC loaded on reset

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-high
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (word_t), always equals curr_pc
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  response instruction word
- inst_valid  out  1  instruction available to decode
- inst  out  32  held instruction
- inst_pc  out  32  address of held instruction
- inst_ready  in  1  decode consumes instruction when inst_valid&&inst_ready
- trap_en, trap_addr  in  1, 32  trap redirect (highest priority)
- branch_en, branch_addr  in  1, 32  taken branch/jump redirect
- fetch_misalign  out  1  one-cycle pulse: redirect target had [1:0]!=0

## Operation
- States: IDLE, REQ, WAIT, VALID, DRAIN. At most one granted request outstanding.
- Redirect: redir = trap_en|branch_en; target = trap_en ? trap_addr : branch_addr. curr_pc <= {target[31:2],2'b00} in every state.
- IDLE: no request; next cycle → REQ.
- REQ: imem_req=1.
  - gnt && !redir → WAIT.
  - gnt && redir → DRAIN.
  - !gnt && redir → stay REQ. Address changes next cycle; changing the address of an ungranted request is legal.
- WAIT:
  - rvalid && !redir → latch inst=imem_rdata, inst_pc=curr_pc; → VALID.
  - rvalid && redir → discard data; → REQ.
  - !rvalid && redir → DRAIN.
- VALID: inst_valid=1.
  - redir → drop instruction; → REQ.
  - else inst_ready → curr_pc <= curr_pc+4; → REQ.
  - else hold inst/inst_pc stable.
- DRAIN: wait for stale rvalid, discard it; → REQ. Further redirects only update curr_pc.
- A redirect beats inst_ready in the same cycle; the instruction is not consumed.
- fetch_misalign pulses the cycle after any redirect with target[1:0]!=0.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: state=IDLE, curr_pc=PC_INIT, imem_req=0, inst_valid=0, inst=0, inst_pc=0, fetch_misalign=0. Reset asserted in any state, including DRAIN, wins; any later stale rvalid is ignored because state is IDLE/REQ. IDLE→REQ means imem_req rises on the 2nd cycle after rst deasserts.
- Zero-wait memory (gnt in REQ cycle, rvalid next cycle): inst_valid rises 2 cycles after imem_req. Back-to-back throughput is 1 instruction per 3 cycles.
- Consume at cycle N → imem_req=1 at N+1 with addr=inst_pc+4.
- Redirect at cycle N → imem_addr=target at N+1 (REQ) or after drain.
- Outputs are registered state decodes; no combinational path from imem_* to inst_valid.

## Structure
- rv32ima_pkg: word_t, new enum fetch_state_t {IDLE,REQ,WAIT,VALID,DRAIN}, constant WORD_BYTES=4.
- Single module, no sub-modules. Redirect priority mux as an always_comb block inside it.

## Test plan
- Reset with PC_INIT=32'h100, zero-wait imem, inst_ready=1 → imem_addr sequence 100,104,108; inst_pc matches; inst equals imem_rdata.
- inst_ready low 5 cycles in VALID → inst/inst_pc stable, imem_req=0; release → next addr 32'h104.
- branch_en with addr 32'h200 in WAIT, rvalid 3 cycles later → that data discarded, never inst_valid; next imem_addr 32'h200.
- trap_en (32'h80) and branch_en (32'h200) same cycle in VALID with inst_ready=1 → instruction dropped, next fetch 32'h80.
- branch_addr 32'h203 → fetch 32'h200, fetch_misalign single pulse next cycle.
- rst asserted during DRAIN, then rvalid → ignored, restart at PC_INIT; PC at 32'hFFFF_FFFC consumed → next addr 0.

Source files
------------

// File: rtl/rv32ima_pkg.sv
// Shared RV32 types and constants for the fetch front end.
package rv32ima_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    DRAIN = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem handshake one request at a
// time, holds the fetched word for decode and drops data made stale by a redirect.
module fetch_ctrl
  import rv32ima_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        trap_en,
  input  logic [31:0] trap_addr,
  input  logic        branch_en,
  input  logic [31:0] branch_addr,
  output logic        fetch_misalign
);

  fetch_state_t state;
  word_t        curr_pc;

  logic         redir;
  word_t        target;
  word_t        redir_pc;
  logic         redir_misalign;

  // Redirect arbitration: trap beats branch; target is forced word aligned.
  always_comb begin
    redir          = trap_en | branch_en;
    target         = trap_en ? trap_addr : branch_addr;
    redir_pc       = {target[31:2], 2'b00};
    redir_misalign = redir & (target[1:0] != 2'b00);
  end

  assign imem_addr = curr_pc;

  // Fetch FSM with registered request/valid outputs and held instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      curr_pc        <= PC_INIT;
      imem_req       <= 1'b0;
      inst_valid     <= 1'b0;
      inst           <= '0;
      inst_pc        <= '0;
      fetch_misalign <= 1'b0;
    end else begin
      fetch_misalign <= redir_misalign;
      // A redirect retargets the PC in every state; VALID's increment below only
      // applies when no redirect is present.
      if (redir) begin
        curr_pc <= redir_pc;
      end

      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end

        REQ: begin
          // Ungranted request may change address freely; granted one must be answered.
          if (imem_gnt) begin
            imem_req <= 1'b0;
            state    <= redir ? DRAIN : WAIT;
          end
        end

        WAIT: begin
          if (imem_rvalid) begin
            if (redir) begin
              state    <= REQ;
              imem_req <= 1'b1;
            end else begin
              inst       <= imem_rdata;
              inst_pc    <= curr_pc;
              inst_valid <= 1'b1;
              state      <= VALID;
            end
          end else if (redir) begin
            state <= DRAIN;
          end
        end

        VALID: begin
          // Redirect wins over a same-cycle consume; the instruction is dropped.
          if (redir) begin
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= REQ;
          end else if (inst_ready) begin
            curr_pc    <= curr_pc + 32'(WORD_BYTES);
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= REQ;
          end
        end

        DRAIN: begin
          // Swallow the stale response of the granted request, then refetch.
          if (imem_rvalid) begin
            imem_req <= 1'b1;
            state    <= REQ;
          end
        end

        default: begin
          state      <= IDLE;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequencing, stall, redirects, misalign, reset, wrap.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        trap_en;
  logic [31:0] trap_addr;
  logic        branch_en;
  logic [31:0] branch_addr;
  logic        fetch_misalign;

  int checks;
  int errors;

  fetch_ctrl #(.PC_INIT(32'h0000_0100)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .trap_en       (trap_en),
    .trap_addr     (trap_addr),
    .branch_en     (branch_en),
    .branch_addr   (branch_addr),
    .fetch_misalign(fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    inst_ready  = 1'b0;
    trap_en     = 1'b0;
    trap_addr   = 32'h0;
    branch_en   = 1'b0;
    branch_addr = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    checks += 6;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
    if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", inst); end
    if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got %h exp 0", inst_pc); end
    if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", fetch_misalign); end
    if (imem_addr !== 32'h100) begin errors++; $display("FAIL reset_addr got %h exp 100", imem_addr); end
    rst = 1'b0;
    step();
    checks += 2;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_exit_req got %b exp 1", imem_req); end
    if (imem_addr !== 32'h100) begin errors++; $display("FAIL reset_exit_addr got %h exp 100", imem_addr); end
  endtask

  // Zero-wait memory, decode always ready: 100, 104, 108.
  task automatic test_sequential();
    logic [31:0] exp_addr;
    logic [31:0] data;
    exp_addr = 32'h100;
    for (int i = 0; i < 3; i++) begin
      data = exp_addr ^ 32'hA5A5_0000;
      checks += 2;
      if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d] got %b exp 1", i, imem_req); end
      if (imem_addr !== exp_addr) begin errors++; $display("FAIL seq_addr[%0d] got %h exp %h", i, imem_addr, exp_addr); end
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      checks += 2;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_wait_req[%0d] got %b exp 0", i, imem_req); end
      if (inst_valid !== 1'b0) begin errors++; $display("FAIL seq_wait_valid[%0d] got %b exp 0", i, inst_valid); end
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      step();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      checks += 3;
      if (inst_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b exp 1", i, inst_valid); end
      if (inst !== data) begin errors++; $display("FAIL seq_inst[%0d] got %h exp %h", i, inst, data); end
      if (inst_pc !== exp_addr) begin errors++; $display("FAIL seq_inst_pc[%0d] got %h exp %h", i, inst_pc, exp_addr); end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      exp_addr = exp_addr + 32'd4;
    end
    checks += 1;
    if (imem_addr !== 32'h10C) begin errors++; $display("FAIL seq_next_addr got %h exp 10c", imem_addr); end
  endtask

  // Decode stalls 5 cycles; instruction must hold, no new request.
  task automatic test_stall();
    do_reset();
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      checks += 4;
      if (inst_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", i, inst_valid); end
      if (inst !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_inst[%0d] got %h exp deadbeef", i, inst); end
      if (inst_pc !== 32'h100) begin errors++; $display("FAIL stall_inst_pc[%0d] got %h exp 100", i, inst_pc); end
      if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %b exp 0", i, imem_req); end
      step();
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    checks += 3;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_release_req got %b exp 1", imem_req); end
    if (imem_addr !== 32'h104) begin errors++; $display("FAIL stall_release_addr got %h exp 104", imem_addr); end
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid got %b exp 0", inst_valid); end
  endtask

  // Branch in WAIT, response arrives 3 cycles later and must be discarded.
  task automatic test_branch_wait();
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    branch_en   = 1'b1;
    branch_addr = 32'h200;
    step();
    branch_en   = 1'b0;
    branch_addr = 32'h0;
    checks += 2;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL brw_drain_req got %b exp 0", imem_req); end
    if (imem_addr !== 32'h200) begin errors++; $display("FAIL brw_drain_addr got %h exp 200", imem_addr); end
    step();
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    checks += 3;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL brw_valid got %b exp 0", inst_valid); end
    if (imem_req !== 1'b1) begin errors++; $display("FAIL brw_req got %b exp 1", imem_req); end
    if (imem_addr !== 32'h200) begin errors++; $display("FAIL brw_addr got %h exp 200", imem_addr); end
    step();
    checks += 1;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL brw_valid_later got %b exp 0", inst_valid); end
  endtask

  // Trap and branch together in VALID with ready high: trap wins, instruction dropped.
  task automatic test_trap_vs_branch();
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0;
    checks += 2;
    if (inst_valid !== 1'b1) begin errors++; $display("FAIL tvb_valid got %b exp 1", inst_valid); end
    if (inst_pc !== 32'h200) begin errors++; $display("FAIL tvb_inst_pc got %h exp 200", inst_pc); end
    trap_en     = 1'b1;
    trap_addr   = 32'h80;
    branch_en   = 1'b1;
    branch_addr = 32'h200;
    inst_ready  = 1'b1;
    step();
    clear_inputs();
    checks += 4;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL tvb_drop got %b exp 0", inst_valid); end
    if (imem_req !== 1'b1) begin errors++; $display("FAIL tvb_req got %b exp 1", imem_req); end
    if (imem_addr !== 32'h80) begin errors++; $display("FAIL tvb_addr got %h exp 80", imem_addr); end
    if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL tvb_misalign got %b exp 0", fetch_misalign); end
  endtask

  // Misaligned branch target on an ungranted request: address aligns, one-cycle pulse.
  task automatic test_misalign();
    branch_en   = 1'b1;
    branch_addr = 32'h203;
    step();
    clear_inputs();
    checks += 3;
    if (imem_addr !== 32'h200) begin errors++; $display("FAIL mis_addr got %h exp 200", imem_addr); end
    if (fetch_misalign !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b exp 1", fetch_misalign); end
    if (imem_req !== 1'b1) begin errors++; $display("FAIL mis_req got %b exp 1", imem_req); end
    step();
    checks += 1;
    if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse_end got %b exp 0", fetch_misalign); end
  endtask

  // Reset during DRAIN; the late stale response must be ignored.
  task automatic test_reset_drain();
    imem_gnt    = 1'b1;
    branch_en   = 1'b1;
    branch_addr = 32'h300;
    step();
    clear_inputs();
    checks += 2;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rd_drain_req got %b exp 0", imem_req); end
    if (imem_addr !== 32'h300) begin errors++; $display("FAIL rd_drain_addr got %h exp 300", imem_addr); end
    rst = 1'b1;
    step();
    checks += 2;
    if (imem_addr !== 32'h100) begin errors++; $display("FAIL rd_rst_addr got %h exp 100", imem_addr); end
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rd_rst_req got %b exp 0", imem_req); end
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD1_BAD1;
    step();
    imem_rvalid = 1'b0;
    checks += 3;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL rd_req got %b exp 1", imem_req); end
    if (imem_addr !== 32'h100) begin errors++; $display("FAIL rd_addr got %h exp 100", imem_addr); end
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL rd_valid got %b exp 0", inst_valid); end
    imem_rvalid = 1'b1;
    step();
    imem_rvalid = 1'b0;
    checks += 2;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_later got %b exp 0", inst_valid); end
    if (imem_req !== 1'b1) begin errors++; $display("FAIL rd_req_later got %b exp 1", imem_req); end
  endtask

  // Consume at 0xFFFF_FFFC wraps the PC to 0.
  task automatic test_wrap();
    branch_en   = 1'b1;
    branch_addr = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    checks += 1;
    if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target got %h exp fffffffc", imem_addr); end
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    step();
    imem_rvalid = 1'b0;
    checks += 2;
    if (inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_inst_pc got %h exp fffffffc", inst_pc); end
    if (inst !== 32'h0000_0013) begin errors++; $display("FAIL wrap_inst got %h exp 13", inst); end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    checks += 2;
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", imem_addr); end
    if (imem_req !== 1'b1) begin errors++; $display("FAIL wrap_req got %b exp 1", imem_req); end
  endtask

  // Response and redirect in the same WAIT cycle: data discarded, refetch at target.
  task automatic test_redir_rvalid();
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD2_BAD2;
    branch_en   = 1'b1;
    branch_addr = 32'h40;
    step();
    clear_inputs();
    checks += 3;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL rr_valid got %b exp 0", inst_valid); end
    if (imem_req !== 1'b1) begin errors++; $display("FAIL rr_req got %b exp 1", imem_req); end
    if (imem_addr !== 32'h40) begin errors++; $display("FAIL rr_addr got %h exp 40", imem_addr); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_trap_vs_branch();
    test_misalign();
    test_reset_drain();
    test_wrap();
    test_redir_rvalid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
